bus2row: RTL

- Unpacks one 39-bit packed row bus (13 cells × 3-bit block codes) back into per-cell 5-bit display codes.
- Streams the row out one cell per handshake, tagged with row and column indices, to the frame/display writer.
- It is the decode/serialise counterpart of the row packer that builds the 39-bit row bus from display codes.
- Sits between the row-bus source (world memory readout) and the display cell writer.

---
 rtl/bus2row.sv | 108 ++++++++++
 1 files changed

// File: rtl/bus2row.sv
// Unpacks a packed row of block codes and streams it out one decoded
// display cell per valid/ready handshake, tagged with row and column.
module bus2row #(
    parameter int NCELLS = 13,
    parameter int BLK_W  = 3,
    parameter int DISP_W = 5,
    parameter int ROW_W  = 6,
    parameter int COL_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCELLS*BLK_W-1:0] row_in,
    input  logic [ROW_W-1:0]        row_id,
    input  logic                    row_valid,
    output logic                    row_ready,
    output logic [DISP_W-1:0]       cell_code,
    output logic [COL_W-1:0]        cell_col,
    output logic [ROW_W-1:0]        cell_row,
    output logic                    cell_valid,
    input  logic                    cell_ready,
    output logic                    row_done,
    input  logic                    clr_err,
    output logic                    bad_code
);

    localparam int BUS_W = NCELLS * BLK_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCELLS - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state;
    logic [BUS_W-1:0]   shreg;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   tag;
    logic               xfer;
    logic               reserved;

    // Block codes 5..7 have no tile meaning and render as the error glyph.
    function automatic logic [DISP_W-1:0] decode(input logic [BLK_W-1:0] blk);
        case (blk)
            BLK_W'(0): decode = DISP_W'(0);
            BLK_W'(1): decode = DISP_W'(3);
            BLK_W'(2): decode = DISP_W'(7);
            BLK_W'(3): decode = DISP_W'(12);
            BLK_W'(4): decode = DISP_W'(18);
            default:   decode = DISP_W'(31);
        endcase
    endfunction

    assign xfer     = (state == EMIT) && cell_ready;
    assign reserved = shreg[BLK_W-1:0] > BLK_W'(4);
    assign cell_col = col;
    assign cell_row = tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            col        <= '0;
            tag        <= '0;
            row_ready  <= 1'b0;
            cell_valid <= 1'b0;
            cell_code  <= '0;
            row_done   <= 1'b0;
            bad_code   <= 1'b0;
        end else begin
            row_done <= 1'b0;

            // A bad transfer in the same cycle as a clear leaves the flag set.
            if (xfer && reserved)
                bad_code <= 1'b1;
            else if (clr_err)
                bad_code <= 1'b0;

            case (state)
                IDLE: begin
                    if (row_valid && row_ready) begin
                        state      <= EMIT;
                        shreg      <= row_in;
                        tag        <= row_id;
                        col        <= '0;
                        cell_code  <= decode(row_in[BLK_W-1:0]);
                        cell_valid <= 1'b1;
                        row_ready  <= 1'b0;
                    end else begin
                        row_ready  <= 1'b1;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (col == LAST_COL) begin
                            state      <= IDLE;
                            cell_valid <= 1'b0;
                            row_ready  <= 1'b1;
                            row_done   <= 1'b1;
                        end else begin
                            shreg     <= shreg >> BLK_W;
                            col       <= col + COL_W'(1);
                            cell_code <= decode(shreg[2*BLK_W-1:BLK_W]);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
